// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the default fetch base address, the RAM word-index width and the
// controller state encoding, plus a helper that picks one instruction
// out of a 64-bit line.
package icache_direct_pkg;

  localparam logic [63:0] PC_START  = 64'h0000_0000_8000_0000;
  localparam int unsigned MEM_IDX_W = 28;
  localparam int unsigned LINE_W    = 64;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  // Select the low (word=0) or high (word=1) instruction of a line.
  function automatic logic [31:0] sel_half(input logic [LINE_W-1:0] line,
                                           input logic              word);
    logic [31:0] res;
    if (word) begin
      res = line[63:32];
    end else begin
      res = line[31:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/icache_tag_data_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// The read port is combinational on the current contents, so a write
// issued in the same cycle is only visible from the next cycle on.
// Valid bits are reset and can be cleared all at once; tags and data
// are plain storage without reset.
module icache_tag_data_array
  import icache_direct_pkg::*;
#(
  parameter int unsigned LINE_NUM = 64,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned TAG_W    = 22
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr_all,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              wr_valid
);

  logic [LINE_NUM-1:0] valid_q;
  logic [LINE_NUM-1:0] valid_d;
  logic [TAG_W-1:0]    tag_mem  [LINE_NUM];
  logic [LINE_W-1:0]   data_mem [LINE_NUM];

  // Next valid vector: a global clear wins over a single line write.
  always_comb begin
    valid_d = valid_q;
    if (clr_all) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_idx] = wr_valid;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data storage, written only on refill.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache with single-cycle hits and a two-cycle
// miss path through a combinational backing RAM.
// Optional build macro ICACHE_PERF_CNT_EN adds 64-bit hit/miss counters
// on ports hit_cnt and miss_cnt.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int unsigned LINE_NUM = 64,
  parameter logic [63:0] PC_BASE  = PC_START
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [63:0]          cmd_addr,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_data,
  input  logic                 flush,
  output logic                 mem_en,
  output logic [MEM_IDX_W-1:0] mem_idx,
  input  logic [LINE_W-1:0]    mem_rdata
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [63:0]          hit_cnt,
  output logic [63:0]          miss_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(LINE_NUM);
  localparam int unsigned TAG_W = MEM_IDX_W - IDX_W;

  // Address split of the incoming request
  logic [63:0]          off_s;
  logic                 req_word_s;
  logic [MEM_IDX_W-1:0] req_lwi_s;
  logic [IDX_W-1:0]     req_idx_s;
  logic [TAG_W-1:0]     req_tag_s;

  // Controller state
  state_e               state_q,     state_d;
  logic                 pend_q,      pend_d;
  logic [MEM_IDX_W-1:0] lat_lwi_q,   lat_lwi_d;
  logic                 lat_word_q,  lat_word_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_data_q,  rsp_data_d;
  logic                 mem_en_q,    mem_en_d;
  logic [MEM_IDX_W-1:0] mem_idx_q,   mem_idx_d;

  // Array interface
  logic                 rd_valid_s;
  logic [TAG_W-1:0]     rd_tag_s;
  logic [LINE_W-1:0]    rd_data_s;
  logic                 wr_en_s;
  logic                 wr_valid_s;
  logic                 clr_all_s;
  logic                 cmd_ready_s;
  logic                 hit_s;
  logic                 miss_s;

  assign off_s      = cmd_addr - PC_BASE;
  assign req_word_s = off_s[2];
  assign req_lwi_s  = off_s[30:3];
  assign req_idx_s  = req_lwi_s[IDX_W-1:0];
  assign req_tag_s  = req_lwi_s[MEM_IDX_W-1:IDX_W];

  logic unused_off_s;
  assign unused_off_s = ^{off_s[63:31], off_s[1:0]};

  icache_tag_data_array #(
    .LINE_NUM (LINE_NUM),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr_all  (clr_all_s),
    .rd_idx   (req_idx_s),
    .rd_valid (rd_valid_s),
    .rd_tag   (rd_tag_s),
    .rd_data  (rd_data_s),
    .wr_en    (wr_en_s),
    .wr_idx   (lat_lwi_q[IDX_W-1:0]),
    .wr_tag   (lat_lwi_q[MEM_IDX_W-1:IDX_W]),
    .wr_data  (mem_rdata),
    .wr_valid (wr_valid_s)
  );

  // Next-state, handshake, lookup and refill control.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    lat_lwi_d   = lat_lwi_q;
    lat_word_d  = lat_word_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    mem_en_d    = 1'b0;
    mem_idx_d   = '0;
    cmd_ready_s = 1'b0;
    wr_en_s     = 1'b0;
    wr_valid_s  = 1'b0;
    clr_all_s   = 1'b0;
    hit_s       = 1'b0;
    miss_s      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_s = ~flush & ~pend_q;
        // A fresh flush or one deferred from a refill clears every line.
        if (flush || pend_q) begin
          clr_all_s = 1'b1;
          pend_d    = 1'b0;
        end else begin
          clr_all_s = 1'b0;
        end
        if (cmd_valid && cmd_ready_s) begin
          if (rd_valid_s && (rd_tag_s == req_tag_s)) begin
            hit_s       = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_data_d  = sel_half(rd_data_s, req_word_s);
          end else begin
            // Latch the request; the RAM is read in the next cycle.
            miss_s     = 1'b1;
            state_d    = REFILL;
            lat_lwi_d  = req_lwi_s;
            lat_word_d = req_word_s;
            mem_en_d   = 1'b1;
            mem_idx_d  = req_lwi_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REFILL: begin
        // Line is installed invalid if a flush arrived during the refill.
        wr_en_s     = reset_n;
        wr_valid_s  = ~(pend_q | flush);
        pend_d      = pend_q | flush;
        rsp_valid_d = 1'b1;
        rsp_data_d  = sel_half(mem_rdata, lat_word_q);
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      lat_lwi_q   <= '0;
      lat_word_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0000_0000;
      mem_en_q    <= 1'b0;
      mem_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      lat_lwi_q   <= lat_lwi_d;
      lat_word_q  <= lat_word_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      mem_en_q    <= mem_en_d;
      mem_idx_q   <= mem_idx_d;
    end
  end

  assign cmd_ready = cmd_ready_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mem_en    = mem_en_q;
  assign mem_idx   = mem_idx_q;

`ifdef ICACHE_PERF_CNT_EN
  logic [63:0] hit_cnt_q,  hit_cnt_d;
  logic [63:0] miss_cnt_q, miss_cnt_d;

  // Counters advance once per hit or miss handshake and wrap naturally.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_s) begin
      hit_cnt_d = hit_cnt_q + 64'd1;
    end else if (miss_s) begin
      miss_cnt_d = miss_cnt_q + 64'd1;
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hit_cnt_q  <= 64'd0;
      miss_cnt_q <= 64'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_perf_s;
  assign unused_perf_s = hit_s ^ miss_s;
`endif

endmodule
